tmds_deserializer_1to10: RTL and testbench

TMDS_DESERIALIZER_1TO10 -- requirements
Module: tmds_deserializer_1to10

---
 rtl/tmds_pkg.sv | 14 +
 rtl/tmds_deserializer_1to10_if.sv | 13 +
 rtl/tmds_decoder_10to8.sv | 17 +
 rtl/tmds_deserializer_1to10.sv | 116 +++++++++++
 tb/tb_tmds_deserializer_1to10.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control token constants, control code type and aligner state encoding
package tmds_pkg;
  typedef logic [1:0] ctrl_t;
  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;
  // Returns {hit, code}; code is only meaningful when hit is set.
  function automatic logic [2:0] tok_lookup(input logic [9:0] s);
    return s == TOK_00 ? 3'b100 : s == TOK_01 ? 3'b101 :
           s == TOK_10 ? 3'b110 : s == TOK_11 ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/tmds_deserializer_1to10_if.sv
// tmds_deserializer_1to10_if: aligned TMDS symbol output bundle
interface tmds_deserializer_1to10_if;
  import tmds_pkg::*;
  logic [9:0] data;
  logic       valid;
  logic       locked;
  ctrl_t      ctrl;
  logic       token;
  logic [7:0] pixel;
  logic       de;
  modport master (output data, valid, locked, ctrl, token, pixel, de);
  modport slave (input data, valid, locked, ctrl, token, pixel, de);
endinterface

// File: rtl/tmds_decoder_10to8.sv
// tmds_decoder_10to8: combinational TMDS 10b symbol to 8b pixel plus data-enable decode
module tmds_decoder_10to8 import tmds_pkg::*; (
  input  logic [9:0] sym_i,
  output logic [7:0] pixel_o,
  output logic       de_o
);
  logic [7:0] d;
  logic [2:0] hit;
  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    hit = tok_lookup(sym_i);
    d = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    pixel_o = d;
    for (int k = 1; k < 8; k++) pixel_o[k] = d[k] ^ d[k-1] ^ ~sym_i[8];
    de_o = ~hit[2];
  end
endmodule

// File: rtl/tmds_deserializer_1to10.sv
// tmds_deserializer_1to10: serial TMDS word aligner; define TMDS_DECODE_EN to add pixel decode
module tmds_deserializer_1to10 import tmds_pkg::*; #(
  parameter int LOCK_TOKENS   = 8,
  parameter int UNLOCK_TOKENS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_data,
  output logic [9:0] o_data,
  output logic       o_valid,
  output logic       o_locked,
  output logic [1:0] o_ctrl,
  output logic       o_token,
  output logic [7:0] o_pixel,
  output logic       o_de
);
  localparam int TW = $clog2(LOCK_TOKENS + 1);
  localparam int MW = $clog2(UNLOCK_TOKENS + 1);
  state_t        state_q, state_d;
  logic [9:0]    sr_q, data_q;
  logic [3:0]    phase_q, phase_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tinc;
  logic [MW-1:0] mcnt_q, mcnt_d, minc;
  logic          seen_q, seen_d, strobe, ph0, valid_q, locked_q, token_q;
  ctrl_t         ctrl_q;
  logic [2:0]    hit;
  // Alignment FSM: token search, phase-0 confirmation, misalignment tracking while locked.
  always_comb begin
    hit = tok_lookup(sr_q);
    ph0 = phase_q == 4'd0;
    tinc = int'(tcnt_q) >= LOCK_TOKENS ? tcnt_q : tcnt_q + 1'b1;
    minc = int'(mcnt_q) >= UNLOCK_TOKENS ? mcnt_q : mcnt_q + 1'b1;
    state_d = state_q;
    tcnt_d = tcnt_q;
    mcnt_d = mcnt_q;
    phase_d = phase_q == 4'd9 ? 4'd0 : phase_q + 4'd1;
    seen_d = ph0 ? 1'b0 : seen_q | hit[2];
    strobe = 1'b0;
    case (state_q)
      SEARCH: if (hit[2]) begin
        state_d = CONFIRM;
        tcnt_d = TW'(1);
        phase_d = 4'd1;
      end
      CONFIRM: if (ph0) begin
        tcnt_d = hit[2] ? tinc : '0;
        state_d = !hit[2] ? SEARCH : int'(tinc) >= LOCK_TOKENS ? LOCKED : CONFIRM;
        mcnt_d = '0;
      end
      LOCKED: if (ph0) begin
        mcnt_d = hit[2] ? '0 : seen_q ? minc : mcnt_q;
        if (int'(mcnt_d) >= UNLOCK_TOKENS) begin
          state_d = SEARCH;
          tcnt_d = '0;
          mcnt_d = '0;
        end else strobe = 1'b1;
      end
      default: state_d = SEARCH;
    endcase
  end
  // Shift register, FSM state and strobed symbol outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEARCH;
      sr_q <= '0;
      phase_q <= '0;
      tcnt_q <= '0;
      mcnt_q <= '0;
      seen_q <= 1'b0;
      valid_q <= 1'b0;
      locked_q <= 1'b0;
      data_q <= '0;
      token_q <= 1'b0;
      ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= {i_data, sr_q[9:1]};
      phase_q <= phase_d;
      tcnt_q <= tcnt_d;
      mcnt_q <= mcnt_d;
      seen_q <= seen_d;
      valid_q <= strobe;
      locked_q <= state_d == LOCKED;
      if (strobe) begin
        data_q <= sr_q;
        token_q <= hit[2];
        if (hit[2]) ctrl_q <= hit[1:0];
      end
    end
  end
  assign o_data = data_q;
  assign o_valid = valid_q;
  assign o_locked = locked_q;
  assign o_ctrl = ctrl_q;
  assign o_token = token_q;
`ifdef TMDS_DECODE_EN
  logic [7:0] pix_d, pixel_q;
  logic       de_d, de_q;
  tmds_decoder_10to8 u_dec (.sym_i(sr_q), .pixel_o(pix_d), .de_o(de_d));
  // Decoded pixel and data enable follow the symbol strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pixel_q <= '0;
      de_q <= 1'b0;
    end else if (strobe) begin
      pixel_q <= pix_d;
      de_q <= de_d;
    end
  end
  assign o_pixel = pixel_q;
  assign o_de = de_q;
`else
  assign o_pixel = '0;
  assign o_de = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_deserializer_1to10.sv
// tb_tmds_deserializer_1to10: random and directed stimulus against a bit-history reference model
module tb_tmds_deserializer_1to10;
  localparam int LOCK = 8;
  localparam int UNLOCK = 4;
  logic clk = 0, rst_n = 1, din = 0;
  tmds_deserializer_1to10_if bus();
  tmds_deserializer_1to10 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din),
    .o_data(bus.data), .o_valid(bus.valid), .o_locked(bus.locked), .o_ctrl(bus.ctrl),
    .o_token(bus.token), .o_pixel(bus.pixel), .o_de(bus.de)
  );
  always #5 clk = ~clk;
  logic [9:0] tok_sym [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] data_sym = 10'b0110100110;
  int n_vec, n_bad, cyc, first_lock;
  bit fell, prev_locked, last_tok, last_de;
  logic [1:0] last_ctrl;
  logic [7:0] last_pix;
  bit hist[$];
  int m_phase, m_st, m_tcnt, m_mcnt;
  bit m_seen, e_valid, e_locked, e_token, e_de;
  logic [9:0] e_data;
  logic [1:0] e_ctrl;
  logic [7:0] e_pixel;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @bit %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [9:0] window();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = hist[i];
    return w;
  endfunction
  function automatic int token_of(logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == tok_sym[k]) return k;
    return -1;
  endfunction
  function automatic logic [7:0] decode_ref(logic [9:0] w);
    int v, r;
    v = w[9] ? 255 - int'(w[7:0]) : int'(w[7:0]);
    r = v & 1;
    for (int i = 1; i < 8; i++) begin
      int x;
      x = ((v >> i) & 1) ^ ((v >> (i - 1)) & 1);
      r = r | ((w[8] ? x : 1 - x) << i);
    end
    return r[7:0];
  endfunction
  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b0);
    m_phase = 0; m_st = 0; m_tcnt = 0; m_mcnt = 0; m_seen = 0;
    e_valid = 0; e_locked = 0; e_token = 0; e_de = 0; e_data = '0; e_ctrl = '0; e_pixel = '0;
  endfunction
  // States: 0 searching, 1 confirming, 2 locked.
  function automatic void model_step(bit b);
    logic [9:0] w;
    int t, np;
    bit ph0, nseen, strobe;
    w = window();
    t = token_of(w);
    ph0 = m_phase == 0;
    np = (m_phase + 1) % 10;
    nseen = ph0 ? 1'b0 : (m_seen | (t >= 0));
    strobe = 0;
    if (m_st == 0) begin
      if (t >= 0) begin m_st = 1; m_tcnt = 1; np = 1; end
    end else if (m_st == 1) begin
      if (ph0) begin
        if (t < 0) begin m_st = 0; m_tcnt = 0; end
        else begin
          m_tcnt++;
          if (m_tcnt >= LOCK) begin m_st = 2; m_mcnt = 0; end
        end
      end
    end else if (ph0) begin
      if (t >= 0) m_mcnt = 0;
      else if (m_seen) m_mcnt++;
      if (m_mcnt >= UNLOCK) begin m_st = 0; m_tcnt = 0; m_mcnt = 0; end
      else strobe = 1;
    end
    e_valid = strobe;
    if (strobe) begin
      e_data = w;
      e_token = t >= 0;
      if (t >= 0) e_ctrl = t[1:0];
`ifdef TMDS_DECODE_EN
      e_pixel = decode_ref(w);
      e_de = t < 0;
`endif
    end
    e_locked = m_st == 2;
    m_phase = np;
    m_seen = nseen;
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction
  task automatic put_bit(bit b);
    din = b;
    @(posedge clk);
    #1;
    model_step(b);
    cyc++;
    check("valid", bus.valid, e_valid);
    check("locked", bus.locked, e_locked);
    check("data", bus.data, e_data);
    check("token", bus.token, e_token);
    check("ctrl", bus.ctrl, e_ctrl);
    check("pixel", bus.pixel, e_pixel);
    check("de", bus.de, e_de);
    if (bus.valid) begin
      last_ctrl = bus.ctrl; last_tok = bus.token; last_pix = bus.pixel; last_de = bus.de;
    end
    if (prev_locked && !bus.locked) fell = 1;
    prev_locked = bus.locked;
    if (bus.locked && first_lock < 0) first_lock = cyc;
  endtask
  task automatic send_sym(logic [9:0] s);
    for (int i = 0; i < 10; i++) put_bit(s[i]);
  endtask
  task automatic do_reset();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("rst_data", bus.data, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_ctrl", bus.ctrl, 0);
    check("rst_token", bus.token, 0);
    check("rst_pixel", bus.pixel, 0);
    check("rst_de", bus.de, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 0; first_lock = -1; fell = 0; prev_locked = 0;
  endtask
  initial begin
    model_reset();
    #3;
    do_reset();
    repeat (3) put_bit(1'b0);
    repeat (20) send_sym(tok_sym[0]);
    check("lock_at_8th", first_lock, 84);
    check("lock38", bus.locked, 1);
    check("data38", bus.data, tok_sym[0]);
    check("ctrl38", bus.ctrl, 0);
    send_sym(data_sym);
    send_sym(tok_sym[0]);
    check("d39_token", last_tok, 0);
`ifdef TMDS_DECODE_EN
    check("d39_pixel", last_pix, 8'hEA);
    check("d39_de", last_de, 1);
`else
    check("d39_pixel", last_pix, 0);
    check("d39_de", last_de, 0);
`endif
    repeat (3) send_sym(tok_sym[0]);
    for (int i = 0; i < 6; i++) begin
      send_sym(tok_sym[$urandom_range(0, 3)]);
      send_sym(10'($urandom_range(0, 1023)));
    end
    send_sym(tok_sym[0]);
    fell = 0;
    put_bit(1'($urandom_range(0, 1)));
    repeat (30) send_sym(tok_sym[0]);
    check("slip_drop", fell, 1);
    check("slip_relock", bus.locked, 1);
    repeat (5) put_bit(tok_sym[0][0]);
    do_reset();
    repeat (7) send_sym(tok_sym[0]);
    check("rst_relock_early", bus.locked, 0);
    repeat (2) send_sym(tok_sym[0]);
    check("rst_relock_at", first_lock, 81);
    do_reset();
    repeat (5) send_sym(tok_sym[0]);
    send_sym(data_sym);
    check("c41_nolock", bus.locked, 0);
    repeat (7) send_sym(tok_sym[0]);
    check("c41_still_off", bus.locked, 0);
    repeat (2) send_sym(tok_sym[0]);
    check("c41_lock_at", first_lock, 141);
    for (int r = 0; r < 12; r++) begin
      send_sym(tok_sym[r % 4]);
      if (r > 0) begin
        check("rot_ctrl", last_ctrl, (r - 1) % 4);
        check("rot_token", last_tok, 1);
      end
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) send_sym(tok_sym[$urandom_range(0, 3)]);
      else send_sym(10'($urandom_range(0, 1023)));
      if ($urandom_range(0, 15) == 0) put_bit(1'($urandom_range(0, 1)));
    end
    repeat (300) put_bit(1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
